instr_fetch: RTL
================

# instr_fetch

Instruction fetch unit: producer side of the decode path. Issues word reads to instruction memory over a request/grant/response handshake, buffers returned instructions with their PC, and presents them to the decode stage (opcode/funct fields feed the main and ALU decoders) over valid/ready. Accepts a one-cycle PC redirect from execute (branch taken or jump, i.e. `PCSrc`) and flushes all wrong-path state.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: instruction buffer entries (power of two, ≥2).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request; held until granted.
- `imem_addr`  out  32  word address of request; bits [1:0] always 0.
- `imem_gnt`  in  1  memory accepts request this cycle (`imem_req & imem_gnt`).
- `imem_rvalid`  in  1  read data valid; exactly one per granted request, ≥1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  buffer head valid.
- `instr`  out  32  head instruction.
- `instr_pc`  out  32  PC of head instruction.
- `instr_ready`  in  1  decode consumes head when `instr_valid & instr_ready`.
- `redirect`  in  1  one-cycle pulse: discard all fetched/in-flight instructions.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] ignored (forced 0).

## Operation
- At most one outstanding memory request.
- FSM states: IDLE, REQ, WAIT, DROP.
- IDLE: if buffer count < DEPTH → REQ with `imem_addr = fetch_pc`.
- REQ: `imem_req`=1, addr stable. On grant → WAIT, `fetch_pc += 4` (wraps mod 2^32).
- WAIT: on `imem_rvalid` push {rdata, pc of request} into buffer → IDLE.
- DROP: request in flight is wrong-path; on `imem_rvalid` discard data → IDLE.
- Issue rule: a request is made only when count < DEPTH, so a response always has a free slot (pops only free space).
- Redirect (highest priority, same cycle as any other event):
  - buffer cleared (count=0, `instr_valid`=0 next cycle); a simultaneous pop is irrelevant.
  - `fetch_pc <= {redirect_pc[31:2],2'b00}`.
  - IDLE → REQ (request for new PC next cycle).
  - REQ without grant this cycle → REQ; address updates to new PC next cycle (request is never withdrawn, only retargeted before grant).
  - REQ with grant this cycle, or WAIT without rvalid → DROP.
  - WAIT with rvalid same cycle → response discarded, → REQ.
  - DROP → DROP (unless rvalid this cycle → REQ).
- Buffer: circular FIFO, simultaneous push and pop allowed when full-minus-nothing; push while full cannot occur (assert in simulation).

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0; state IDLE, `fetch_pc`=RESET_PC, count 0.
- Reset assertion mid-transaction: all state cleared immediately; any later `imem_rvalid` for the old request is the memory's problem (memory is reset together).
- First `imem_req` one cycle after `reset_n` deasserts.
- Response in cycle N → `instr_valid` in cycle N+1 (registered, no bypass).
- Steady state with grant-same-cycle and 1-cycle memory: one instruction per 3 cycles (REQ, WAIT, IDLE).
- Redirect in cycle N → new-PC `imem_req` no earlier than N+1; no wrong-path instruction visible at decode from N+1 onward.
- Outputs `instr`/`instr_pc` stable while `instr_valid & ~instr_ready`.

## Structure
- Shared package `riscv_pkg`: `fetch_state_t` enum (IDLE, REQ, WAIT, DROP), `XLEN`=32, `INSTR_BYTES`=4.
- One sub-module: `fetch_fifo` (DEPTH entries × 64 bits {pc, instr}, push/pop/flush, count, full/empty).
- Top holds FSM, `fetch_pc`, request logic.

## Test plan
- Reset, memory grants immediately, rvalid 1 cycle later, ready=1: addresses 0x0,0x4,0x8 requested; instr_pc sequence 0x0,0x4,0x8 with matching words.
- instr_ready=0 for 20 cycles: exactly 2 instructions buffered, `imem_req` stays 0 after second response; head stays PC 0x0.
- Redirect to 0x103 while in WAIT: old response dropped, next request addr 0x100, first instr_pc 0x100.
- Redirect in REQ with grant withheld: `imem_addr` changes to redirect PC next cycle, req never deasserts.
- Redirect coincident with rvalid and with a pop: buffer empty next cycle, response not delivered, request to new PC issued.
- fetch_pc at 0xFFFF_FFFC: next request address 0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: FSM state encoding, buffer entry
// layout and the word-alignment helper used for every fetch address.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory request/response, decode-side
// valid/ready and the execute-stage redirect.
interface instr_fetch_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries. Flush wins over push/pop;
// the head is read straight from storage so it stays put until popped.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           do_push_s;
  logic           do_pop_s;

  // Qualify requests against occupancy; a push into a full buffer is only
  // honoured when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && (count_r != {CW{1'b0}})) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && ((count_r != CW'(DEPTH)) || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/fetch_fifo_chk.sv
// Simulation-only invariants of the fetch buffer: the single-outstanding
// issue rule must never let a response land in a full buffer.
module fetch_fifo_chk #(
  parameter int DEPTH = 2
) (
  input logic                   clk,
  input logic                   reset_n,
  input logic                   push,
  input logic                   pop,
  input logic                   full,
  input logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && full && !pop));

  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
    count <= CW'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding word reads from imem, buffered
// {pc, instr} delivery to decode, and redirect-driven wrong-path squashing.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input logic          clk,
  input logic          reset_n,
  instr_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state_r;
  fetch_state_t    state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] req_pc_r;
  logic            imem_req_r;

  logic            grant_s;
  logic            push_s;
  logic            pop_s;
  logic            flush_s;
  fetch_entry_t    push_data_s;
  fetch_entry_t    head_s;
  logic [CW-1:0]   count_s;
  logic            full_s;
  logic            empty_s;

  assign grant_s = (state_r == REQ) && bus.imem_gnt;

  // Buffer control: redirect squashes everything, including a same-cycle
  // response or pop.
  always_comb begin
    flush_s           = bus.redirect;
    push_s            = (state_r == WAIT) && bus.imem_rvalid && !bus.redirect;
    pop_s             = !empty_s && bus.instr_ready && !bus.redirect;
    push_data_s.pc    = req_pc_r;
    push_data_s.instr = bus.imem_rdata;
  end

  // Next-state logic; redirect retargets or squashes whatever is in flight
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.redirect) begin
          state_nxt_s = REQ;
        end else if (count_s < CW'(DEPTH)) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (grant_s) begin
          state_nxt_s = bus.redirect ? DROP : WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          state_nxt_s = bus.redirect ? REQ : IDLE;
        end else if (bus.redirect) begin
          state_nxt_s = DROP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DROP: begin
        if (bus.imem_rvalid) begin
          state_nxt_s = bus.redirect ? REQ : IDLE;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC, PC of the in-flight request, and the registered request strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_r <= word_align(RESET_PC);
      req_pc_r   <= {XLEN{1'b0}};
      imem_req_r <= 1'b0;
    end else begin
      if (bus.redirect) begin
        fetch_pc_r <= word_align(bus.redirect_pc);
      end else if (grant_s) begin
        fetch_pc_r <= fetch_pc_r + XLEN'(INSTR_BYTES);
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      if (grant_s) begin
        req_pc_r <= fetch_pc_r;
      end else begin
        req_pc_r <= req_pc_r;
      end
      imem_req_r <= (state_nxt_s == REQ);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (flush_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  fetch_fifo_chk #(
    .DEPTH (DEPTH)
  ) u_fifo_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .full    (full_s),
    .count   (count_s)
  );

  // imem_addr is fetch_pc directly: it only moves on grant (req drops) or on
  // a redirect retarget, so it is stable whenever a request is pending.
  assign bus.imem_req    = imem_req_r;
  assign bus.imem_addr   = fetch_pc_r;
  assign bus.instr_valid = !empty_s;
  assign bus.instr       = head_s.instr;
  assign bus.instr_pc    = head_s.pc;

endmodule
